// File: rtl/bist_sig_analyzer.sv
// bist_sig_analyzer: scan BIST output-response analyzer compacting cut_sdo into a SISR and checking it against GOLDEN
// Ports: clk, reset (async, active-high), bistmode (run request / abort / acknowledge),
//   cut_sdo (serial CUT scan-out), cut_scanmode (high while capturing),
//   bistdone (run complete, held until bistmode drops), bistpass (signature matched GOLDEN),
//   sig_obs (signature register view, present only when BIST_SIG_OBS_EN is defined)
module bist_sig_analyzer #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] POLY     = 16'h1021,
    parameter logic [WIDTH-1:0] SEED     = 16'h0000,
    parameter int               NUM_BITS = 160,
    parameter logic [WIDTH-1:0] GOLDEN   = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bistmode,
    input  logic             cut_sdo,
    output logic             cut_scanmode,
    output logic             bistdone,
    output logic             bistpass
`ifdef BIST_SIG_OBS_EN
    ,
    output logic [WIDTH-1:0] sig_obs
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
    localparam logic [15:0] LAST = 16'(NUM_BITS - 1);
    state_t           state, state_n;
    logic [WIDTH-1:0] sig, sig_n, sig_shift;
    logic [15:0]      cnt, cnt_n;
    logic             scan_n, done_n, pass_n, fb;
`ifdef BIST_SIG_OBS_EN
    assign sig_obs = sig;
`endif
    assign fb        = sig[WIDTH-1] ^ cut_sdo;
    assign sig_shift = {sig[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sig          <= SEED;
            cnt          <= '0;
            cut_scanmode <= 1'b0;
            bistdone     <= 1'b0;
            bistpass     <= 1'b0;
        end else begin
            state        <= state_n;
            sig          <= sig_n;
            cnt          <= cnt_n;
            cut_scanmode <= scan_n;
            bistdone     <= done_n;
            bistpass     <= pass_n;
        end
    end
    always_comb begin
        state_n = state;
        sig_n   = sig;
        cnt_n   = cnt;
        scan_n  = cut_scanmode;
        done_n  = bistdone;
        pass_n  = bistpass;
        case (state)
            IDLE: if (bistmode) begin
                state_n = RUN;
                sig_n   = SEED;
                cnt_n   = '0;
                scan_n  = 1'b1;
            end
            RUN: if (!bistmode) begin
                state_n = IDLE;
                scan_n  = 1'b0;
                done_n  = 1'b0;
                pass_n  = 1'b0;
            end else begin
                sig_n   = sig_shift;
                cnt_n   = cnt + 16'd1;
                state_n = (cnt == LAST) ? CHECK : RUN;
                scan_n  = (cnt != LAST);
            end
            CHECK: begin
                state_n = DONE;
                done_n  = 1'b1;
                pass_n  = (sig == GOLDEN);
            end
            DONE: if (!bistmode) begin
                state_n = IDLE;
                done_n  = 1'b0;
                pass_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                scan_n  = 1'b0;
                done_n  = 1'b0;
                pass_n  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_bist_sig_analyzer.sv
// tb_bist_sig_analyzer: directed and randomized checks of bist_sig_analyzer against a polynomial-division model
module tb_bist_sig_analyzer;
    logic clk = 0, reset = 1;
    logic bm = 0, sdo = 0, bm2 = 0, sdo2 = 0;
    logic scan, done, pass, scan2, done2, pass2, scan3, done3, pass3;
    int checks = 0, failures = 0;
    int hi;
    bit q[$];
    logic [15:0] exp_sig;
`ifdef BIST_SIG_OBS_EN
    logic [15:0] obs1, obs2, obs3;
`endif

    always #5 clk = ~clk;

    bist_sig_analyzer dut (.clk(clk), .reset(reset), .bistmode(bm), .cut_sdo(sdo),
        .cut_scanmode(scan), .bistdone(done), .bistpass(pass)
`ifdef BIST_SIG_OBS_EN
        , .sig_obs(obs1)
`endif
    );
    bist_sig_analyzer #(.NUM_BITS(2), .GOLDEN(16'h2042)) dut2 (.clk(clk), .reset(reset), .bistmode(bm2),
        .cut_sdo(sdo2), .cut_scanmode(scan2), .bistdone(done2), .bistpass(pass2)
`ifdef BIST_SIG_OBS_EN
        , .sig_obs(obs2)
`endif
    );
    bist_sig_analyzer #(.NUM_BITS(2), .GOLDEN(16'h2043)) dut3 (.clk(clk), .reset(reset), .bistmode(bm2),
        .cut_sdo(sdo2), .cut_scanmode(scan3), .bistdone(done3), .bistpass(pass3)
`ifdef BIST_SIG_OBS_EN
        , .sig_obs(obs3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Signature as the remainder of the stream polynomial times x^16 modulo x^16 + POLY, seeded with 0
    function automatic logic [15:0] model(input bit s[$]);
        logic [16:0] r = '0;
        foreach (s[i]) begin
            r = {r[15:0], 1'b0} ^ {s[i], 16'h0000};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    // Bits that cancel the remainder's top bit, driving the signature to zero after 16 of them
    task automatic zero_tail();
        logic [15:0] s;
        repeat (16) begin
            s = model(q);
            q.push_back(s[15]);
        end
    endtask

    // Full 160-bit run on dut from IDLE using q, then acknowledge
    task automatic run160(input string tag);
        exp_sig = model(q);
        bm = 1;
        step();
        hi = 0;
        for (int i = 0; i < 160; i++) begin
            if (scan) hi++;
            sdo = q[i];
            step();
        end
        chk({tag, "_scan_cycles"}, hi, 160);
        chk({tag, "_scan_off"}, scan, 0);
        chk({tag, "_done_early"}, done, 0);
        step();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_pass"}, pass, exp_sig == 16'h0000);
    endtask

    initial begin
        step();
        chk("rst_scan", scan, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        reset = 0;
        step();
        chk("idle_scan", scan, 0);

        q = {};
        repeat (160) q.push_back(1'b0);
        run160("zero");
        repeat (20) begin
            step();
            chk("hold_done", done, 1);
            chk("hold_pass", pass, 1);
        end
        bm = 0;
        step();
        chk("ack_done", done, 0);
        chk("ack_pass", pass, 0);
        bm = 1;
        step();
        chk("restart_scan", scan, 1);

        for (int i = 1; i < 50; i++) begin
            sdo = 1'($urandom);
            step();
        end
        bm = 0;
        step();
        chk("abort_scan", scan, 0);
        chk("abort_done", done, 0);
        step();
        chk("abort_idle_done", done, 0);

        q = {};
        repeat (144) q.push_back(1'($urandom));
        zero_tail();
        run160("rand_zero_tail");
        bm = 0;
        step();
        q = {};
        repeat (160) q.push_back(1'($urandom));
        run160("rand_full");
        bm = 0;
        step();
        q = {};
        repeat (160) q.push_back(1'b0);
        run160("zero_again");

        bm = 0;
        step();
        bm = 1;
        step();
        repeat (5) step();
        #2 reset = 1;
        #1 chk("rst_mid_scan", scan, 0);
        chk("rst_mid_done", done, 0);
        @(negedge clk);
        reset = 0;
        bm = 0;
        step();
        chk("post_rst_scan", scan, 0);
        q = {};
        repeat (160) q.push_back(1'b0);
        run160("post_rst");
        #2 reset = 1;
        #1 chk("rst_done_flag", done, 0);
        chk("rst_pass_flag", pass, 0);
        @(negedge clk);
        reset = 0;
        bm = 1;
        step();
        chk("rst_release_idle_start", scan, 1);
        bm = 0;
        step();

        bm2 = 1;
        step();
        chk("two_e0_scan", scan2, 1);
`ifdef BIST_SIG_OBS_EN
        chk("two_obs_e0", obs2, 16'h0000);
`endif
        sdo2 = 1;
        step();
`ifdef BIST_SIG_OBS_EN
        chk("two_obs_e1", obs2, 16'h1021);
`endif
        sdo2 = 0;
        step();
        chk("two_e2_scan", scan2, 0);
`ifdef BIST_SIG_OBS_EN
        chk("two_obs_e2", obs2, 16'h2042);
`endif
        step();
        chk("two_done_a", done2, 1);
        chk("two_pass_a", pass2, 1);
        chk("two_done_b", done3, 1);
        chk("two_pass_b", pass3, 0);
        bm2 = 0;
        step();
        chk("two_ack", done2, 0);

        bm2 = 1;
        step();
        sdo2 = 1;
        step();
        sdo2 = 0;
        step();
        bm2 = 0;
        step();
        chk("check_low_done", done2, 1);
        chk("check_low_pass", pass2, 1);
        step();
        chk("check_low_idle", done2, 0);
        chk("check_low_pass_clr", pass2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
